// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared types and widths for the alarm sequencer: FSM state encoding, time field widths and
// the alarm-time comparison used to start a ring.
package alarm_ring_ctrl_pkg;

  localparam int unsigned HourW = 5;
  localparam int unsigned MinW  = 6;
  localparam int unsigned SecW  = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } alarm_state_e;

  // Alarm fires only at second 0 of the programmed minute.
  function automatic logic alarm_hit(logic [HourW-1:0] cur_hour, logic [MinW-1:0] cur_min,
                                     logic [SecW-1:0] cur_sec, logic [HourW-1:0] alm_hour,
                                     logic [MinW-1:0] alm_min);
    return (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == '0);
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the timekeeper/buttons, the alarm sequencer and the flow-LED block.
interface alarm_ring_ctrl_if;
  import alarm_ring_ctrl_pkg::*;

  logic             sec_tick;
  logic [HourW-1:0] cur_hour;
  logic [MinW-1:0]  cur_min;
  logic [SecW-1:0]  cur_sec;
  logic [HourW-1:0] alm_hour;
  logic [MinW-1:0]  alm_min;
  logic             alm_en;
  logic             snooze_btn;
  logic             stop_btn;
  logic             led_power;
  logic             sig_ring;
  logic             sig_step;
  logic             ringing;
  logic             snoozing;

  modport master (
    output sec_tick, cur_hour, cur_min, cur_sec, alm_hour, alm_min, alm_en, snooze_btn, stop_btn,
    input  led_power, sig_ring, sig_step, ringing, snoozing
  );

  modport slave (
    input  sec_tick, cur_hour, cur_min, cur_sec, alm_hour, alm_min, alm_en, snooze_btn, stop_btn,
    output led_power, sig_ring, sig_step, ringing, snoozing
  );

endinterface

// File: rtl/alarm_ring_ctrl_step_divider.sv
// Free-running flow-LED step clock: high for the first half of each STEP_DIV-cycle period, with
// one-cycle strobes marking its rising and falling edges. First rise lands on the first wrap.
module step_divider #(
  parameter int unsigned STEP_DIV = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sig_step_o,
  output logic step_rise_o,
  output logic step_fall_o
);

  localparam int unsigned CntW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(STEP_DIV - 1);
  localparam logic [CntW-1:0] Half = CntW'(STEP_DIV / 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            sig_q, sig_d;
  logic            rise_q, fall_q;
  logic            wrap;

  always_comb begin
    wrap  = (cnt_q == Last);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    // Held low until the first wrap so the first rise comes STEP_DIV cycles after reset.
    run_d = run_q | wrap;
    sig_d = run_d & (cnt_d < Half);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      sig_q  <= sig_d;
      rise_q <= sig_d & ~sig_q;
      fall_q <= ~sig_d & sig_q;
    end
  end

  assign sig_step_o  = sig_q;
  assign step_rise_o = rise_q;
  assign step_fall_o = fall_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: IDLE/RING/SNOOZE control, second countdowns, and the sweep request that
// re-triggers the flow-LED block every RESTART_STEPS step rises while ringing.
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int unsigned STEP_DIV      = 25_000_000,
  parameter int unsigned RING_SECS     = 30,
  parameter int unsigned SNOOZE_SECS   = 300,
  parameter int unsigned MAX_SNOOZE    = 3,
  parameter int unsigned RESTART_STEPS = 6
) (
  input logic               clk,
  input logic               rst_n,
  alarm_ring_ctrl_if.slave  bus_io
);

  localparam int unsigned RingW   = $clog2(RING_SECS + 1);
  localparam int unsigned SnoozeW = $clog2(SNOOZE_SECS + 1);
  localparam int unsigned UsedW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int unsigned EdgeW   = $clog2(RESTART_STEPS + 1);

  alarm_state_e       state_q, state_d;
  logic [RingW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SnoozeW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [UsedW-1:0]   snooze_used_q, snooze_used_d;
  logic [EdgeW-1:0]   edge_cnt_q, edge_cnt_d;
  logic               req_q, req_d;
  logic               seen_q, seen_d;
  logic               ringing_q, snoozing_q;
  logic               step_rise, step_fall;
  logic               quit;

  step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_divider (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sig_step_o  (bus_io.sig_step),
    .step_rise_o (step_rise),
    .step_fall_o (step_fall)
  );

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_cnt_d  = snooze_cnt_q;
    snooze_used_d = snooze_used_q;
    quit          = bus_io.stop_btn | ~bus_io.alm_en;

    unique case (state_q)
      StIdle: begin
        if (bus_io.sec_tick && bus_io.alm_en &&
            alarm_hit(bus_io.cur_hour, bus_io.cur_min, bus_io.cur_sec,
                      bus_io.alm_hour, bus_io.alm_min)) begin
          state_d       = StRing;
          ring_cnt_d    = RingW'(RING_SECS);
          snooze_used_d = '0;
        end
      end
      StRing: begin
        if (quit) begin
          state_d = StIdle;
        end else if (bus_io.snooze_btn) begin
          if (snooze_used_q < UsedW'(MAX_SNOOZE)) begin
            state_d       = StSnooze;
            snooze_cnt_d  = SnoozeW'(SNOOZE_SECS);
            snooze_used_d = snooze_used_q + 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (bus_io.sec_tick) begin
          ring_cnt_d = (ring_cnt_q != '0) ? ring_cnt_q - 1'b1 : '0;
          if (ring_cnt_q <= RingW'(1)) state_d = StIdle;
        end
      end
      StSnooze: begin
        if (quit) begin
          state_d = StIdle;
        end else if (bus_io.sec_tick) begin
          snooze_cnt_d = (snooze_cnt_q != '0) ? snooze_cnt_q - 1'b1 : '0;
          if (snooze_cnt_q <= SnoozeW'(1)) begin
            state_d    = StRing;
            ring_cnt_d = RingW'(RING_SECS);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sweep request: raised on RING entry and every RESTART_STEPS rises, dropped on the fall that
  // follows the first rise it was high for, so the LED block samples it exactly once.
  always_comb begin
    req_d      = req_q;
    seen_d     = seen_q;
    edge_cnt_d = edge_cnt_q;
    if (state_d != StRing) begin
      req_d      = 1'b0;
      seen_d     = 1'b0;
      edge_cnt_d = '0;
    end else if (state_q != StRing) begin
      req_d      = 1'b1;
      seen_d     = 1'b0;
      edge_cnt_d = '0;
    end else begin
      if (step_rise) begin
        if (req_q) seen_d = 1'b1;
        if (edge_cnt_q == EdgeW'(RESTART_STEPS - 1)) begin
          edge_cnt_d = '0;
          req_d      = 1'b1;
          seen_d     = 1'b0;
        end else begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
      if (step_fall && seen_q) begin
        req_d  = 1'b0;
        seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ring_cnt_q    <= '0;
      snooze_cnt_q  <= '0;
      snooze_used_q <= '0;
      edge_cnt_q    <= '0;
      req_q         <= 1'b0;
      seen_q        <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_cnt_q  <= snooze_cnt_d;
      snooze_used_q <= snooze_used_d;
      edge_cnt_q    <= edge_cnt_d;
      req_q         <= req_d;
      seen_q        <= seen_d;
      ringing_q     <= (state_d == StRing);
      snoozing_q    <= (state_d == StSnooze);
    end
  end

  assign bus_io.led_power = ringing_q;
  assign bus_io.ringing   = ringing_q;
  assign bus_io.snoozing  = snoozing_q;
  assign bus_io.sig_ring  = req_q;

endmodule
